kavach_ewma_ctrl: RTL and testbench
===================================

Name: kavach_ewma_ctrl

Overview:
Sequencing and configuration controller for the per-channel EWMA baseline engine. It gates each channel's sample strobe into the engine and drives the per-channel alpha shift. A fast-alpha warm-up runs first, then normal tracking. Baseline updates are frozen while an attack is in progress so that anomalous samples cannot poison the learned baselines.

Parameters:
NUM_CHANNELS, 5, number of EWMA channels controlled
MAX_SHIFT, 8, width of each shift field
SCORE_WIDTH, 8, width of each anomaly score
WARM_SHIFT, 2, shift value used while a channel is in warm-up (alpha = 1/4)
WARM_SAMPLES, 32, accepted samples per channel before its warm-up completes (range 1-255)
FREEZE_HOLD, 64, cycles the freeze is held after multi_domain_alert deasserts (range 1-255)
SCORE_FREEZE_TH, 8'd128, per-channel score at or above which that channel is masked

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run controller; low forces IDLE
rebase  in  1  single-cycle pulse requesting re-learn of all baselines
sensor_valid  in  NUM_CHANNELS  raw per-channel sample-valid from the domain monitors
track_shift  in  MAX_SHIFT  shift applied to channels that have finished warm-up
score_bus  in  NUM_CHANNELS*SCORE_WIDTH  per-channel engine scores; ch0 occupies the LSBs
multi_domain_alert  in  1  fused multi-domain alert from the engine
sample_valid  out  NUM_CHANNELS  gated strobes to the engine
shift_cfg_bus  out  NUM_CHANNELS*MAX_SHIFT  per-channel shift to the engine; ch0 occupies the LSBs
use_cfg_shift  out  1  high when state != IDLE
ctrl_state  out  2  00 IDLE, 01 WARMUP, 10 TRACK, 11 FREEZE
warm_done  out  NUM_CHANNELS  per-channel warm-up complete
chan_mask  out  NUM_CHANNELS  per-channel score mask (registered)
freeze_events  out  8  saturating count of entries into FREEZE

Behaviour:
- Reset values: state IDLE; all warm counters 0; hold_cnt 0; warm_done 0; chan_mask 0; freeze_events 0; use_cfg_shift 0. sample_valid is 0 during reset because the state is IDLE.
- sample_valid is combinational from registered gating: sensor_valid & gate. This gives zero latency, so the engine samples the same-cycle data.
  - IDLE: gate = 0.
  - WARMUP: gate = all ones.
  - TRACK: gate = ~chan_mask.
  - FREEZE: gate = 0.
- shift_cfg_bus[ch] is registered: WARM_SHIFT when warm_done[ch]=0, else track_shift.
- Warm counter[ch], width 8: increments on each sample_valid[ch] while in WARMUP and saturates at WARM_SAMPLES. warm_done[ch] is set on the cycle after the counter reaches WARM_SAMPLES.
- chan_mask[ch] <= (score[ch] >= SCORE_FREEZE_TH) when in TRACK; 0 in all other states.
- State transitions, evaluated in priority order:
  - enable=0 in any state -> IDLE; counters and warm_done are preserved.
  - IDLE & enable -> WARMUP. Warm counters and warm_done are cleared on entry.
  - rebase in WARMUP/TRACK/FREEZE -> WARMUP. Counters, warm_done, hold_cnt and chan_mask are cleared.
  - WARMUP -> TRACK when &warm_done. multi_domain_alert is ignored in WARMUP.
  - TRACK & multi_domain_alert -> FREEZE. hold_cnt <= FREEZE_HOLD; freeze_events increments, saturating at 255.
  - FREEZE: while the alert is high, hold_cnt reloads FREEZE_HOLD. While the alert is low, hold_cnt decrements. hold_cnt == 1 with the alert low -> TRACK on the next edge, so exactly FREEZE_HOLD low-alert cycles are spent in FREEZE.
- Simultaneous events:
  - rebase together with an alert in TRACK -> WARMUP, with no freeze_events increment.
  - enable low together with rebase -> IDLE.
- Reset asserted mid-operation returns all state immediately (asynchronously). No partial strobe is produced.

Decomposition:
- Package kavach_ewma_pkg holds:
  - the ctrl_state encoding constants IDLE/WARMUP/TRACK/FREEZE;
  - a channel index constant for each channel: CH_PWR_V=0, CH_PWR_I=1, CH_TIMING=2, CH_TEMP=3, CH_IPC=4.
- One sub-module, kavach_warm_counter, is instantiated per channel via generate. It contains the saturating sample counter plus warm_done, with clear, inc and done ports.

Test Plan:
- Warm-up: enable=1 with sensor_valid=5'b11111 every cycle.
  - shift_cfg_bus fields = 2 for 32 accepted samples.
  - warm_done=5'h1F after that, then ctrl_state=10 and all shift fields = track_shift (e.g. 6).
- Uneven warm-up: only ch0-ch3 valid for 40 cycles.
  - warm_done=5'h0F and the state stays WARMUP.
  - After 32 ch4 samples the state goes to TRACK.
- Channel mask: in TRACK, drive score ch2=200 and the others 10 with sensor_valid all 1.
  - The cycle after, chan_mask=5'b00100 and sample_valid=5'b11011.
  - Score ch2=100 -> mask clears the next cycle.
- Freeze hold: in TRACK, pulse multi_domain_alert for 5 cycles.
  - State goes to FREEZE and sample_valid=0.
  - Exactly 64 cycles after the alert falls, the state returns to TRACK.
  - freeze_events=1. Re-asserting the alert at hold_cnt=10 reloads it to 64.
- Rebase plus priority: in FREEZE, pulse rebase together with the alert.
  - State goes to WARMUP, warm_done=0 and shift fields = 2.
  - Then enable=0 together with rebase -> IDLE, use_cfg_shift=0, sample_valid=0.
- Async reset: assert rst_n=0 mid-TRACK between clock edges.
  - All outputs go to their reset values immediately: ctrl_state=00, freeze_events=0.

Source files
------------

// File: rtl/kavach_ewma_pkg.sv
// Shared encodings for the EWMA baseline sequencing controller.
package kavach_ewma_pkg;

  // Controller state encoding, also presented directly on ctrl_state.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WARMUP = 2'b01,
    TRACK  = 2'b10,
    FREEZE = 2'b11
  } ctrl_state_t;

  // Channel indices into the per-channel buses.
  localparam int CH_PWR_V  = 0;
  localparam int CH_PWR_I  = 1;
  localparam int CH_TIMING = 2;
  localparam int CH_TEMP   = 3;
  localparam int CH_IPC    = 4;

endpackage

// File: rtl/kavach_warm_counter.sv
// Per-channel warm-up sample counter. Saturates at WARM_SAMPLES; done
// rises the cycle after the count reaches the terminal value.
module kavach_warm_counter #(
  parameter int WARM_SAMPLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam logic [7:0] WARM_TC = 8'(WARM_SAMPLES);

  logic [7:0] cnt;

  // Saturating count of accepted samples; clear wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 8'd0;
      done <= 1'b0;
    end else if (clear) begin
      cnt  <= 8'd0;
      done <= 1'b0;
    end else begin
      if (inc && (cnt != WARM_TC)) cnt <= cnt + 8'd1;
      done <= (cnt == WARM_TC);
    end
  end

endmodule

// File: rtl/kavach_ewma_ctrl.sv
// Sequencing controller for the per-channel EWMA baseline engine: gates
// sample strobes, drives per-channel alpha shift, and freezes learning
// while a multi-domain attack is in progress.
//
// state  | meaning
// IDLE   | controller off, no strobes, engine uses its own shift
// WARMUP | all strobes pass, fast alpha until each channel has its samples
// TRACK  | normal tracking, channels with high scores are masked
// FREEZE | no strobes; held until the alert has been low FREEZE_HOLD cycles
module kavach_ewma_ctrl
  import kavach_ewma_pkg::*;
#(
  parameter int NUM_CHANNELS = 5,
  parameter int MAX_SHIFT    = 8,
  parameter int SCORE_WIDTH  = 8,
  parameter int WARM_SHIFT   = 2,
  parameter int WARM_SAMPLES = 32,
  parameter int FREEZE_HOLD  = 64,
  parameter logic [SCORE_WIDTH-1:0] SCORE_FREEZE_TH = 8'd128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              rebase,
  input  logic [NUM_CHANNELS-1:0]           sensor_valid,
  input  logic [MAX_SHIFT-1:0]              track_shift,
  input  logic [NUM_CHANNELS*SCORE_WIDTH-1:0] score_bus,
  input  logic                              multi_domain_alert,
  output logic [NUM_CHANNELS-1:0]           sample_valid,
  output logic [NUM_CHANNELS*MAX_SHIFT-1:0] shift_cfg_bus,
  output logic                              use_cfg_shift,
  output logic [1:0]                        ctrl_state,
  output logic [NUM_CHANNELS-1:0]           warm_done,
  output logic [NUM_CHANNELS-1:0]           chan_mask,
  output logic [7:0]                        freeze_events
);

  localparam logic [MAX_SHIFT-1:0] WARM_SHIFT_V = MAX_SHIFT'(WARM_SHIFT);
  localparam logic [7:0]           HOLD_V       = 8'(FREEZE_HOLD);

  ctrl_state_t               state;
  logic [7:0]                hold_cnt;
  logic [NUM_CHANNELS-1:0]   gate;
  logic [NUM_CHANNELS-1:0]   score_hit;
  logic [NUM_CHANNELS-1:0]   warm_inc;
  logic                      warm_clear;

  // Strobe gating decoded from registered state and mask only, so the
  // engine sees the same-cycle sensor strobe with no added latency.
  always_comb begin
    gate = '0;
    case (state)
      WARMUP:  gate = '1;
      TRACK:   gate = ~chan_mask;
      default: gate = '0;
    endcase
  end

  assign sample_valid  = sensor_valid & gate;
  assign use_cfg_shift = (state != IDLE);
  assign ctrl_state    = state;

  // Warm-up restarts on leaving IDLE and on any honoured rebase.
  assign warm_clear = enable && ((state == IDLE) || rebase);

  // Per-channel threshold compare of the engine scores.
  always_comb begin
    score_hit = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      score_hit[ch] = (score_bus[ch*SCORE_WIDTH +: SCORE_WIDTH] >= SCORE_FREEZE_TH);
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_warm
    assign warm_inc[ch] = (state == WARMUP) && sample_valid[ch];

    kavach_warm_counter #(
      .WARM_SAMPLES(WARM_SAMPLES)
    ) u_warm (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(warm_clear),
      .inc  (warm_inc[ch]),
      .done (warm_done[ch])
    );
  end

  // Per-channel shift: fast alpha until that channel's warm-up completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cfg_bus <= {NUM_CHANNELS{WARM_SHIFT_V}};
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        shift_cfg_bus[ch*MAX_SHIFT +: MAX_SHIFT] <= warm_done[ch] ? track_shift : WARM_SHIFT_V;
      end
    end
  end

  // Controller FSM with freeze hold timer, channel mask and event count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= 8'd0;
      chan_mask     <= '0;
      freeze_events <= 8'd0;
    end else if (!enable) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      chan_mask <= '0;
    end else if (state == IDLE) begin
      state     <= WARMUP;
      hold_cnt  <= 8'd0;
      chan_mask <= '0;
    end else if (rebase) begin
      // Rebase outranks a same-cycle alert, so no freeze is counted.
      state     <= WARMUP;
      hold_cnt  <= 8'd0;
      chan_mask <= '0;
    end else begin
      case (state)
        WARMUP: begin
          chan_mask <= '0;
          if (&warm_done) state <= TRACK;
        end
        TRACK: begin
          chan_mask <= score_hit;
          if (multi_domain_alert) begin
            state    <= FREEZE;
            hold_cnt <= HOLD_V;
            if (freeze_events != 8'hFF) freeze_events <= freeze_events + 8'd1;
          end
        end
        FREEZE: begin
          chan_mask <= '0;
          if (multi_domain_alert) begin
            hold_cnt <= HOLD_V;
          end else if (hold_cnt <= 8'd1) begin
            state    <= TRACK;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          chan_mask <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kavach_ewma_ctrl.sv
// Directed bench for kavach_ewma_ctrl. Stimulus pushes expected values into
// a scoreboard queue; a monitor pops and compares them on the falling edge
// (or immediately, for the asynchronous reset check).
module tb_kavach_ewma_ctrl;
  import kavach_ewma_pkg::*;

  localparam int N  = 5;
  localparam int MS = 8;
  localparam int SW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            rebase;
  logic [N-1:0]    sensor_valid;
  logic [MS-1:0]   track_shift;
  logic [N*SW-1:0] score_bus;
  logic            multi_domain_alert;
  logic [N-1:0]    sample_valid;
  logic [N*MS-1:0] shift_cfg_bus;
  logic            use_cfg_shift;
  logic [1:0]      ctrl_state;
  logic [N-1:0]    warm_done;
  logic [N-1:0]    chan_mask;
  logic [7:0]      freeze_events;

  kavach_ewma_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .rebase            (rebase),
    .sensor_valid      (sensor_valid),
    .track_shift       (track_shift),
    .score_bus         (score_bus),
    .multi_domain_alert(multi_domain_alert),
    .sample_valid      (sample_valid),
    .shift_cfg_bus     (shift_cfg_bus),
    .use_cfg_shift     (use_cfg_shift),
    .ctrl_state        (ctrl_state),
    .warm_done         (warm_done),
    .chan_mask         (chan_mask),
    .freeze_events     (freeze_events)
  );

  always #5 clk = ~clk;

  typedef enum int {K_STATE, K_SV, K_SHIFT, K_WDONE, K_MASK, K_FEV, K_USE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [39:0] exp;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event chk_ev;

  localparam logic [39:0] SH_WARM  = 40'h0202020202;
  localparam logic [39:0] SH_TRACK = 40'h0606060606;

  task automatic expect_val(input kind_t k, input logic [39:0] v, input int tag);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch2_score(input logic [SW-1:0] v);
    logic [N*SW-1:0] s;
    s = {N{8'h0A}};
    s[CH_TIMING*SW +: SW] = v;
    score_bus = s;
  endtask

  function automatic logic [39:0] actual(input kind_t k);
    case (k)
      K_STATE: return 40'(ctrl_state);
      K_SV:    return 40'(sample_valid);
      K_SHIFT: return 40'(shift_cfg_bus);
      K_WDONE: return 40'(warm_done);
      K_MASK:  return 40'(chan_mask);
      K_FEV:   return 40'(freeze_events);
      default: return 40'(use_cfg_shift);
    endcase
  endfunction

  // Monitor: drain and compare all pending expectations.
  initial begin
    exp_t        e;
    logic [39:0] a;
    forever begin
      @(negedge clk or chk_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = actual(e.kind);
        n_checks++;
        if (a === e.exp) n_pass++;
        else $display("FAIL %s tag=%0d actual=%h expected=%h", e.kind.name(), e.tag, a, e.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    rebase = 1'b0;
    sensor_valid = '0;
    track_shift = 8'd6;
    score_bus = {N{8'h0A}};
    multi_domain_alert = 1'b0;

    // Reset values
    #1;
    expect_val(K_STATE, 40'd0, 1);
    expect_val(K_FEV,   40'd0, 2);
    expect_val(K_WDONE, 40'd0, 3);
    expect_val(K_MASK,  40'd0, 4);
    expect_val(K_SV,    40'd0, 5);
    expect_val(K_USE,   40'd0, 6);
    expect_val(K_SHIFT, SH_WARM, 7);
    step(2);
    rst_n = 1'b1;

    // Full warm-up
    enable = 1'b1;
    sensor_valid = 5'h1F;
    step(1);
    expect_val(K_STATE, 40'd1, 10);
    expect_val(K_SV,    40'h1F, 11);
    expect_val(K_SHIFT, SH_WARM, 12);
    expect_val(K_USE,   40'd1, 13);
    step(32);
    expect_val(K_WDONE, 40'h00, 14);
    expect_val(K_STATE, 40'd1, 15);
    expect_val(K_SHIFT, SH_WARM, 16);
    step(1);
    expect_val(K_WDONE, 40'h1F, 17);
    expect_val(K_STATE, 40'd1, 18);
    step(1);
    expect_val(K_STATE, 40'd2, 19);
    expect_val(K_SHIFT, SH_TRACK, 20);

    // Uneven warm-up via rebase from TRACK
    rebase = 1'b1;
    sensor_valid = 5'h0F;
    step(1);
    expect_val(K_STATE, 40'd1, 30);
    expect_val(K_WDONE, 40'd0, 31);
    rebase = 1'b0;
    step(40);
    expect_val(K_WDONE, 40'h0F, 32);
    expect_val(K_STATE, 40'd1, 33);
    expect_val(K_SHIFT, 40'h0206060606, 34);
    sensor_valid = 5'h10;
    step(33);
    expect_val(K_STATE, 40'd1, 35);
    expect_val(K_WDONE, 40'h1F, 36);
    step(1);
    expect_val(K_STATE, 40'd2, 37);
    expect_val(K_SHIFT, SH_TRACK, 38);

    // Channel mask
    sensor_valid = 5'h1F;
    set_ch2_score(8'd200);
    step(1);
    expect_val(K_MASK, 40'h04, 40);
    expect_val(K_SV,   40'h1B, 41);
    set_ch2_score(8'd100);
    step(1);
    expect_val(K_MASK, 40'h00, 42);
    expect_val(K_SV,   40'h1F, 43);
    set_ch2_score(8'd10);

    // Freeze hold: 5-cycle alert pulse, then exactly 64 low cycles
    multi_domain_alert = 1'b1;
    step(1);
    expect_val(K_STATE, 40'd3, 50);
    expect_val(K_SV,    40'h00, 51);
    expect_val(K_FEV,   40'd1, 52);
    step(4);
    multi_domain_alert = 1'b0;
    step(63);
    expect_val(K_STATE, 40'd3, 53);
    step(1);
    expect_val(K_STATE, 40'd2, 54);
    expect_val(K_FEV,   40'd1, 55);

    // Alert re-asserted at hold_cnt=10 reloads the hold
    multi_domain_alert = 1'b1;
    step(1);
    expect_val(K_FEV, 40'd2, 60);
    multi_domain_alert = 1'b0;
    step(54);
    expect_val(K_STATE, 40'd3, 61);
    multi_domain_alert = 1'b1;
    step(1);
    multi_domain_alert = 1'b0;
    step(63);
    expect_val(K_STATE, 40'd3, 62);
    step(1);
    expect_val(K_STATE, 40'd2, 63);

    // Rebase together with alert in FREEZE
    multi_domain_alert = 1'b1;
    step(1);
    expect_val(K_STATE, 40'd3, 70);
    expect_val(K_FEV,   40'd3, 71);
    rebase = 1'b1;
    step(1);
    expect_val(K_STATE, 40'd1, 72);
    expect_val(K_WDONE, 40'd0, 73);
    rebase = 1'b0;
    multi_domain_alert = 1'b0;
    step(1);
    expect_val(K_SHIFT, SH_WARM, 74);
    step(33);
    expect_val(K_STATE, 40'd2, 75);

    // Rebase together with alert in TRACK: no freeze counted
    rebase = 1'b1;
    multi_domain_alert = 1'b1;
    step(1);
    expect_val(K_STATE, 40'd1, 80);
    expect_val(K_FEV,   40'd3, 81);
    multi_domain_alert = 1'b0;

    // enable low together with rebase
    enable = 1'b0;
    step(1);
    expect_val(K_STATE, 40'd0, 82);
    expect_val(K_USE,   40'd0, 83);
    expect_val(K_SV,    40'h00, 84);
    rebase = 1'b0;

    // Async reset mid-TRACK, between clock edges
    enable = 1'b1;
    step(35);
    expect_val(K_STATE, 40'd2, 90);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val(K_STATE, 40'd0, 91);
    expect_val(K_FEV,   40'd0, 92);
    expect_val(K_SV,    40'h00, 93);
    expect_val(K_USE,   40'd0, 94);
    expect_val(K_WDONE, 40'h00, 95);
    ->chk_ev;
    step(2);
    expect_val(K_STATE, 40'd0, 96);
    expect_val(K_SHIFT, SH_WARM, 97);
    step(1);
    rst_n = 1'b1;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      $display("FAIL drain pending=%0d required=0", sbq.size());
      n_checks += sbq.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
